// File: rtl/avaliador_seq_if.sv
// Answer-entry handshake and grade/status bus between the entry logic and avaliador_seq.
interface avaliador_seq_if #(
  parameter int P_WIDTH = 4,
  parameter int NUM_Q   = 8
);
  localparam int SW = $clog2(NUM_Q + 1);

  logic               start;
  logic               clear;
  logic               ans_valid;
  logic [P_WIDTH-1:0] ans;
  logic [P_WIDTH-1:0] key;
  logic [1:0]         y;
  logic [SW-1:0]      score;
  logic               busy;
  logic               done;

  modport master (
    output start, clear, ans_valid, ans, key,
    input  y, score, busy, done
  );

  modport slave (
    input  start, clear, ans_valid, ans, key,
    output y, score, busy, done
  );
endinterface

// File: rtl/avaliador_seq.sv
// Sequential answer evaluator: collects NUM_Q answers, scores matches against the key,
// grades the score through three thresholds and shows the grade on one 7-segment digit.
module avaliador_seq #(
  parameter int P_WIDTH = 4,
  parameter int NUM_Q   = 8,
  parameter int T_PASS  = 4,
  parameter int T_GOOD  = 6,
  parameter int T_EXC   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  avaliador_seq_if.slave  bus,
  output logic            seg_a,
  output logic            seg_b,
  output logic            seg_c,
  output logic            seg_d,
  output logic            seg_e,
  output logic            seg_f,
  output logic            seg_g
);
  localparam int SW = $clog2(NUM_Q + 1);

  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_Q - 1);
  localparam logic [SW-1:0] TH_PASS  = SW'(T_PASS);
  localparam logic [SW-1:0] TH_GOOD  = SW'(T_GOOD);
  localparam logic [SW-1:0] TH_EXC   = SW'(T_EXC);

  // Segment patterns, packed as {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam logic [6:0] SEG_DASH  = 7'b000_0001;
  localparam logic [6:0] SEG_0     = 7'b111_1110;
  localparam logic [6:0] SEG_1     = 7'b011_0000;
  localparam logic [6:0] SEG_2     = 7'b110_1101;
  localparam logic [6:0] SEG_3     = 7'b111_1001;

  typedef enum logic [1:0] {IDLE, COLLECT, GRADE, SHOW} state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      score, score_nxt;
  logic [SW-1:0]      idx, idx_nxt;
  logic [1:0]         y, y_nxt;
  logic [1:0]         grade;
  logic [6:0]         seg, seg_nxt;
  logic [P_WIDTH-1:0] ans_w, key_w;

  assign ans_w = bus.ans;
  assign key_w = bus.key;

  always_comb begin
    if (score >= TH_EXC)       grade = 2'd3;
    else if (score >= TH_GOOD) grade = 2'd2;
    else if (score >= TH_PASS) grade = 2'd1;
    else                       grade = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      score <= '0;
      idx   <= '0;
      y     <= '0;
      seg   <= SEG_BLANK;
    end else begin
      state <= state_nxt;
      score <= score_nxt;
      idx   <= idx_nxt;
      y     <= y_nxt;
      seg   <= seg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    score_nxt = score;
    idx_nxt   = idx;
    y_nxt     = y;
    seg_nxt   = SEG_BLANK;

    if (bus.clear) begin
      state_nxt = IDLE;
      score_nxt = '0;
      idx_nxt   = '0;
      y_nxt     = '0;
    end else begin
      unique case (state)
        IDLE, SHOW: begin
          if (bus.start) begin
            state_nxt = COLLECT;
            score_nxt = '0;
            idx_nxt   = '0;
          end
        end
        COLLECT: begin
          if (bus.ans_valid) begin
            idx_nxt = idx + SW'(1);
            if (ans_w == key_w) score_nxt = score + SW'(1);
            if (idx == LAST_IDX) state_nxt = GRADE;
          end
        end
        GRADE: begin
          y_nxt     = grade;
          state_nxt = SHOW;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Display follows the next state and next grade so it switches on the same edge
    unique case (state_nxt)
      COLLECT, GRADE: seg_nxt = SEG_DASH;
      SHOW: begin
        unique case (y_nxt)
          2'd0:    seg_nxt = SEG_0;
          2'd1:    seg_nxt = SEG_1;
          2'd2:    seg_nxt = SEG_2;
          default: seg_nxt = SEG_3;
        endcase
      end
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  assign bus.y     = y;
  assign bus.score = score;
  assign bus.busy  = (state == COLLECT) || (state == GRADE);
  assign bus.done  = (state == SHOW);

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
endmodule
